// File: rtl/pc_register_ctrl_if.sv
// rtl/pc_register_ctrl_if.sv - PC register control bus; PC_TRACE_EN adds trace outputs
interface pc_register_ctrl_if;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_type;
  logic        alu_zero;
  logic        alu_gt;
  logic        exc_ack;
  logic [31:0] pc;
  logic [31:0] epc;
  logic        pc_loaded;
  logic        misalign_exc;
`ifdef PC_TRACE_EN
  logic [31:0] trace_count;
  logic [31:0] last_branch_target;
`endif

  modport master (
    output pc_next, pc_write, pc_write_cond, branch_type, alu_zero, alu_gt, exc_ack,
`ifdef PC_TRACE_EN
    input  trace_count, last_branch_target,
`endif
    input  pc, epc, pc_loaded, misalign_exc
  );

  modport slave (
    input  pc_next, pc_write, pc_write_cond, branch_type, alu_zero, alu_gt, exc_ack,
`ifdef PC_TRACE_EN
    output trace_count, last_branch_target,
`endif
    output pc, epc, pc_loaded, misalign_exc
  );
endinterface

// File: rtl/pc_register_ctrl.sv
// rtl/pc_register_ctrl.sv - program counter with branch resolution and misalign fault; PC_TRACE_EN adds load tracing
module pc_register_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic clk,
  input  logic reset,
  pc_register_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FAULT = 2'b01
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        loaded_q, loaded_d;
  logic        cond;
  logic        load_req;
  logic        misaligned;

  always_comb begin
    case (bus.branch_type)
      2'b00:   cond = bus.alu_zero;
      2'b01:   cond = !bus.alu_zero;
      2'b10:   cond = bus.alu_gt;
      default: cond = !bus.alu_gt;
    endcase
  end

  assign load_req   = bus.pc_write | (bus.pc_write_cond & cond);
  assign misaligned = ALIGN_CHECK && (bus.pc_next[1:0] != 2'b00);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    loaded_d = 1'b0;
    case (state_q)
      RUN: begin
        if (load_req) begin
          if (misaligned) begin
            epc_d   = pc_q;
            state_d = FAULT;
          end else begin
            pc_d     = bus.pc_next;
            loaded_d = 1'b1;
          end
        end
      end
      FAULT: begin
        // load requests are dropped until the control unit acknowledges
        if (bus.exc_ack) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      epc_q    <= 32'h0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      loaded_q <= loaded_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.epc          = epc_q;
  assign bus.pc_loaded    = loaded_q;
  assign bus.misalign_exc = (state_q == FAULT);

`ifdef PC_TRACE_EN
  logic [31:0] trace_count_q;
  logic [31:0] last_branch_target_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      trace_count_q        <= 32'h0;
      last_branch_target_q <= 32'h0;
    end else begin
      if (loaded_d) trace_count_q <= trace_count_q + 32'd1;
      // only a taken conditional branch counts; pc_write takes priority
      if (loaded_d && !bus.pc_write) last_branch_target_q <= bus.pc_next;
    end
  end

  assign bus.trace_count        = trace_count_q;
  assign bus.last_branch_target = last_branch_target_q;
`endif

endmodule

// File: doc/pc_register_ctrl.md
Name: pc_register_ctrl

Overview:
- Program-counter state element directly downstream of the PC-source selection mux. Its next-value input comes from that mux's 32-bit output.
- Decides each cycle whether the PC loads: unconditional jump/sequential write, or conditional branch write resolved from ALU flags.
- Detects misaligned targets, captures the faulting PC into an EPC register, and holds the PC in a fault state until the control unit acknowledges.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ALIGN_CHECK, 1, 1 enables the misaligned-target check; 0 treats every target as aligned.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- pc_next  input  32  candidate next PC from PC-source mux
- pc_write  input  1  unconditional load request
- pc_write_cond  input  1  conditional (branch) load request
- branch_type  input  2  00 beq, 01 bne, 10 bgt, 11 ble
- alu_zero  input  1  ALU result-zero flag
- alu_gt  input  1  ALU greater-than flag
- exc_ack  input  1  control unit acknowledges fault
- pc  output  32  current PC
- epc  output  32  PC value at last fault
- pc_loaded  output  1  one-cycle pulse: PC was updated this edge
- misalign_exc  output  1  level: fault state active

Behaviour:
- Reset (clk edge with reset=1): pc=RESET_PC, epc=0, pc_loaded=0, misalign_exc=0, state=RUN. Reset overrides every other input, including mid-fault.
- Branch condition cond: beq = alu_zero; bne = !alu_zero; bgt = alu_gt; ble = !alu_gt.
- load_req = pc_write | (pc_write_cond & cond). pc_write has priority, so cond is irrelevant when pc_write=1.
- misaligned = ALIGN_CHECK & (pc_next[1:0] != 2'b00).
- State RUN:
  - load_req & !misaligned: pc <= pc_next, pc_loaded=1 for the following cycle; stay RUN.
  - load_req & misaligned: pc unchanged, epc <= pc (current value), pc_loaded=0; go FAULT.
  - No load_req: all state held, pc_loaded=0.
- State FAULT:
  - misalign_exc=1 for the whole state.
  - pc_write and pc_write_cond are ignored; pc and epc are held.
  - exc_ack=1: go RUN next cycle. misalign_exc drops the same cycle the state returns to RUN. No load occurs on the ack cycle.
  - exc_ack while in RUN has no effect.
- Latency:
  - PC update is visible on pc one clock after the request cycle.
  - pc_loaded is registered and asserted in the same cycle that pc shows the new value.
- pc_loaded is a single-cycle pulse. Back-to-back loads produce consecutive 1s.
- Wrap-around: pc_next=32'hFFFF_FFFC loads normally. No arithmetic is done inside the block.
- Unused state encodings recover to RUN on the next edge.

Optional Feature:
- Macro: PC_TRACE_EN.
- Defined: adds outputs trace_count (32) and last_branch_target (32), both reset to 0.
  - trace_count increments on every edge where pc_loaded is set and wraps 32'hFFFF_FFFF -> 0.
  - last_branch_target <= pc_next whenever a pc_write_cond load succeeds with pc_write=0.
- Undefined: neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- Reset: assert reset 2 cycles with pc_write=1, pc_next=32'h40 -> pc=0, epc=0, pc_loaded=0, misalign_exc=0.
- Unconditional load: pc_write=1, pc_next=32'h0000_0004 for 1 cycle -> next cycle pc=4, pc_loaded=1; following idle cycle pc_loaded=0, pc=4.
- Conditional branch:
  - pc_write_cond=1, branch_type=00, alu_zero=0, pc_next=32'h100 -> pc unchanged, pc_loaded=0.
  - Repeat with alu_zero=1 -> pc=32'h100.
  - branch_type=11, alu_gt=0, pc_next=32'h200 -> pc=32'h200.
- Misalign fault: pc=32'h8, pc_write=1, pc_next=32'h0000_0102 -> pc stays 8, epc=8, misalign_exc=1.
  - pc_write=1 with pc_next=32'h10 during fault -> ignored.
  - exc_ack=1 -> misalign_exc=0 next cycle; then pc_write, pc_next=32'h10 -> pc=32'h10.
- Reset mid-fault: in FAULT, assert reset -> pc=RESET_PC, epc=0, misalign_exc=0, state RUN.
- PC_TRACE_EN: 3 successful loads (one via branch to 32'h300) plus 1 failed branch -> trace_count=3, last_branch_target=32'h300.
